// File: rtl/wb_burst_reader_pkg.sv
// Shared constants and state type for the Wishbone burst read master.
package wb_burst_reader_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    SPACE,
    BURST
  } state_e;

endpackage

// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 read-side bus bundle between the burst reader and its slave.
interface wb_burst_reader_if;

  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_sm;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_rty;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_cti, wb_bte,
    input  wb_dat_sm, wb_ack, wb_err, wb_rty
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_cti, wb_bte,
    output wb_dat_sm, wb_ack, wb_err, wb_rty
  );

endinterface

// File: rtl/wb_burst_reader_sync_fifo.sv
// First-word fall-through FIFO with occupancy count; DEPTH must be a power of 2.
module sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Pop only when data is present; a push on full is allowed when a pop frees the slot.
  always_comb begin
    pop      = rd_en && (count_q != '0);
    push     = wr_en && ((count_q != CW'(DEPTH)) || pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Head word is forced to zero while empty so the output never shows stale data.
  always_comb begin
    empty   = (count_q == '0);
    count   = count_q;
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone B4 incrementing-burst read master feeding a FWFT FIFO for a streaming consumer.
module wb_burst_reader
  import wb_burst_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned NUM_WORDS  = 2048,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  wb_burst_reader_if.master   wb,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int unsigned RW = $clog2(NUM_WORDS + 1);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_e          state_q, state_d;
  logic [31:0]     adr_q, adr_d;
  logic [RW-1:0]   remaining_q, remaining_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [2:0]      cti_q, cti_d;
  logic            cyc_q, cyc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_push;
  logic [31:0]     outstanding, free, blen;
  logic            unused_rty;

  // Retry needs no handling: without ack the beat simply stays on the bus.
  assign unused_rty = wb.wb_rty;

  // Next-state logic; free space excludes beats already promised to the current burst.
  always_comb begin
    outstanding = (state_q == BURST) ? 32'(beats_q) : '0;
    free        = 32'(FIFO_DEPTH) - 32'(fifo_count) - outstanding;
    blen        = (32'(remaining_q) < BURST_LEN) ? 32'(remaining_q) : BURST_LEN;

    state_d     = state_q;
    adr_d       = adr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    cti_d       = cti_q;
    cyc_d       = cyc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    fifo_push   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SPACE;
          adr_d       = BASE_ADDR;
          remaining_d = RW'(NUM_WORDS);
          error_d     = 1'b0;
          busy_d      = 1'b1;
        end
      end
      SPACE: begin
        if (free >= blen) begin
          beats_d = BW'(blen);
          cyc_d   = 1'b1;
          cti_d   = (blen == 32'd1) ? CTI_END : CTI_INC;
          state_d = BURST;
        end
      end
      BURST: begin
        if (wb.wb_err) begin
          error_d = 1'b1;
          cyc_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wb.wb_ack) begin
          fifo_push   = 1'b1;
          adr_d       = adr_q + 32'd4;
          beats_d     = beats_q - BW'(1);
          remaining_d = remaining_q - RW'(1);
          cti_d       = (beats_q == BW'(2)) ? CTI_END : CTI_INC;
          if (beats_q == BW'(1)) begin
            cyc_d = 1'b0;
            cti_d = CTI_CLASSIC;
            if (remaining_q == RW'(1)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = SPACE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, address, counters and registered bus/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      cti_q       <= CTI_CLASSIC;
      cyc_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      cti_q       <= cti_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_push),
    .wr_data (wb.wb_dat_sm),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Output drive.
  always_comb begin
    wb.wb_cyc = cyc_q;
    wb.wb_stb = cyc_q;
    wb.wb_we  = 1'b0;
    wb.wb_sel = 4'hF;
    wb.wb_adr = adr_q;
    wb.wb_cti = cti_q;
    wb.wb_bte = BTE_LINEAR;
    busy      = busy_q;
    done      = done_q;
    error     = error_q;
    out_valid = !fifo_empty;
  end

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench: randomized Wishbone slave and consumer, transfer model from address arithmetic.
module tb_wb_burst_reader;

  localparam logic [31:0] BASE = 32'hFFFF_FF80;
  localparam int unsigned NW   = 33;
  localparam int unsigned BL   = 16;
  localparam int unsigned FD   = 32;

  logic        clk, rst_n, start, busy, done, error, out_valid, out_ready;
  logic [31:0] out_data;

  wb_burst_reader_if wb();

  wb_burst_reader #(
    .BASE_ADDR(BASE), .NUM_WORDS(NW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .wb(wb), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned lat_max, wait_cnt, wait_tgt, rdy_pct;
  int unsigned beat_no, err_beat, rty_beat, rty_left;
  int unsigned done_cnt, cyc_rise;
  logic        cyc_prev;
  logic [31:0] salt;
  logic [31:0] beat_adr_q[$];
  logic [2:0]  beat_cti_q[$];
  logic [31:0] rty_adr_q[$];
  logic [2:0]  rty_cti_q[$];
  logic [31:0] rx_q[$];

  // Reference model: beat i of a transfer.
  function automatic logic [31:0] exp_adr(int unsigned i);
    return BASE + 32'(i) * 32'd4;
  endfunction
  function automatic logic [2:0] exp_cti(int unsigned i);
    return (((i % BL) == BL - 1) || (i == NW - 1)) ? 3'b111 : 3'b010;
  endfunction
  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Slave: random ack latency, optional retry run and err (with ack) on a chosen beat.
  always @(negedge clk) begin
    wb.wb_ack = 1'b0;
    wb.wb_err = 1'b0;
    wb.wb_rty = 1'b0;
    if (!rst_n) begin
      wait_cnt = 0;
    end else if (wb.wb_cyc && wb.wb_stb) begin
      if (wait_cnt < wait_tgt) begin
        wait_cnt++;
      end else if (rty_beat == beat_no + 1 && rty_left > 0) begin
        wb.wb_rty = 1'b1;
        rty_left--;
        rty_adr_q.push_back(wb.wb_adr);
        rty_cti_q.push_back(wb.wb_cti);
      end else begin
        beat_no++;
        wb.wb_dat_sm = word_of(wb.wb_adr);
        wb.wb_ack    = 1'b1;
        if (beat_no == err_beat) begin
          wb.wb_err = 1'b1;
        end else begin
          beat_adr_q.push_back(wb.wb_adr);
          beat_cti_q.push_back(wb.wb_cti);
        end
        wait_cnt = 0;
        wait_tgt = $urandom_range(lat_max, 0);
      end
    end
  end

  // Consumer and event monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (wb.wb_cyc && !cyc_prev) cyc_rise++;
    end
    cyc_prev  = wb.wb_cyc;
    out_ready = ($urandom_range(99, 0) < rdy_pct);
    if (out_ready && out_valid) rx_q.push_back(out_data);
  end

  task automatic prep();
    beat_no = 0; done_cnt = 0; cyc_rise = 0; err_beat = 0; rty_beat = 0; rty_left = 0;
    wait_tgt = 0; wait_cnt = 0;
    beat_adr_q.delete(); beat_cti_q.delete(); rty_adr_q.delete(); rty_cti_q.delete(); rx_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    int unsigned n = 0;
    while (done_cnt == 0 && n < 4000) begin @(posedge clk); #1; n++; end
    to = (done_cnt == 0);
  endtask

  task automatic wait_rx(input int unsigned want, output bit to);
    int unsigned n = 0;
    while (rx_q.size() < want && n < 2000) begin @(posedge clk); #1; n++; end
    to = (rx_q.size() < want);
  endtask

  task automatic wait_beats(input int unsigned want, output bit to);
    int unsigned n = 0;
    while (beat_no < want && n < 2000) begin @(posedge clk); #1; n++; end
    to = (beat_no < want);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rdy_pct = 100; lat_max = 0;
    prep();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    checks++; if (wb.wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b want 0", wb.wb_cyc); end
    checks++; if (wb.wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", wb.wb_stb); end
    checks++; if (wb.wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb.wb_we); end
    checks++; if (wb.wb_sel !== 4'hF) begin errors++; $display("FAIL reset_sel got %h want f", wb.wb_sel); end
    checks++; if (wb.wb_adr !== 32'h0) begin errors++; $display("FAIL reset_adr got %h want 0", wb.wb_adr); end
    checks++; if (wb.wb_cti !== 3'b000) begin errors++; $display("FAIL reset_cti got %b want 000", wb.wb_cti); end
    checks++; if (wb.wb_bte !== 2'b00) begin errors++; $display("FAIL reset_bte got %b want 00", wb.wb_bte); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Full transfer: beat addresses/cti, burst count, data order, single done pulse.
  task automatic test_transfer(input string nm, input int unsigned lat, input int unsigned rdy);
    bit to;
    prep();
    lat_max = lat; rdy_pct = rdy; salt = $urandom;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b want 1", nm, busy); end
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL %s done_timeout got none want pulse", nm); end
    wait_rx(NW, to);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (beat_adr_q.size() != NW) begin errors++; $display("FAIL %s beat_count got %0d want %0d", nm, beat_adr_q.size(), NW); end
    for (int i = 0; i < beat_adr_q.size() && i < NW; i++) begin
      checks++;
      if (beat_adr_q[i] !== exp_adr(i) || beat_cti_q[i] !== exp_cti(i)) begin
        errors++; $display("FAIL %s beat%0d got adr %h cti %b want adr %h cti %b", nm, i, beat_adr_q[i], beat_cti_q[i], exp_adr(i), exp_cti(i));
      end
    end
    checks++; if (rx_q.size() != NW) begin errors++; $display("FAIL %s word_count got %0d want %0d", nm, rx_q.size(), NW); end
    for (int i = 0; i < rx_q.size() && i < NW; i++) begin
      checks++;
      if (rx_q[i] !== word_of(exp_adr(i))) begin errors++; $display("FAIL %s word%0d got %h want %h", nm, i, rx_q[i], word_of(exp_adr(i))); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_cycles got %0d want 1", nm, done_cnt); end
    checks++; if (cyc_rise != 3) begin errors++; $display("FAIL %s bursts got %0d want 3", nm, cyc_rise); end
    checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL %s end_status got busy %b err %b want 0 0", nm, busy, error); end
  endtask

  // Consumer stalled: two bursts fill the FIFO, the short third waits for one pop.
  task automatic test_backpressure();
    bit to;
    prep();
    lat_max = 1; rdy_pct = 0; salt = $urandom;
    pulse_start();
    wait_beats(32, to);
    repeat (40) @(posedge clk);
    #1;
    checks++; if (beat_no != 32) begin errors++; $display("FAIL bp_beats_when_full got %0d want 32", beat_no); end
    checks++; if (wb.wb_cyc !== 1'b0) begin errors++; $display("FAIL bp_cyc_when_full got %b want 0", wb.wb_cyc); end
    checks++; if (cyc_rise != 2) begin errors++; $display("FAIL bp_bursts_when_full got %0d want 2", cyc_rise); end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_status got busy %b valid %b want 1 1", busy, out_valid); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL bp_early_done got %0d want 0", done_cnt); end
    rdy_pct = 100;
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL bp_done_timeout got none want pulse"); end
    wait_rx(NW, to);
    #1;
    checks++; if (cyc_rise != 3) begin errors++; $display("FAIL bp_bursts got %0d want 3", cyc_rise); end
    checks++; if (rx_q.size() != NW) begin errors++; $display("FAIL bp_word_count got %0d want %0d", rx_q.size(), NW); end
    for (int i = 0; i < rx_q.size() && i < NW; i++) begin
      checks++;
      if (rx_q[i] !== word_of(exp_adr(i))) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, rx_q[i], word_of(exp_adr(i))); end
    end
  endtask

  // err (together with ack) on beat 5, then restart clears error and runs back to back.
  task automatic test_error();
    bit to;
    prep();
    lat_max = 0; rdy_pct = 0; salt = $urandom; err_beat = 5;
    pulse_start();
    wait_beats(5, to);
    checks++; if (to) begin errors++; $display("FAIL err_beat_timeout got %0d want 5", beat_no); end
    checks++; if (wb.wb_cyc !== 1'b0 || wb.wb_stb !== 1'b0) begin errors++; $display("FAIL err_cyc_drop got %b%b want 00", wb.wb_cyc, wb.wb_stb); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", busy); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL err_no_done got %0d want 0", done_cnt); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", error); end
    rdy_pct = 100;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL err_fifo_words got %0d want 4", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      checks++;
      if (rx_q[i] !== word_of(exp_adr(i))) begin errors++; $display("FAIL err_word%0d got %h want %h", i, rx_q[i], word_of(exp_adr(i))); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_fifo_drained got %b want 0", out_valid); end
    prep();
    lat_max = 2;
    pulse_start();
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_restart got err %b busy %b want 0 1", error, busy); end
    wait_done(to);
    wait_rx(NW, to);
    #1;
    checks++; if (rx_q.size() != NW) begin errors++; $display("FAIL err_restart_words got %0d want %0d", rx_q.size(), NW); end
    for (int i = 0; i < rx_q.size() && i < NW; i++) begin
      checks++;
      if (rx_q[i] !== word_of(exp_adr(i))) begin errors++; $display("FAIL err_restart_word%0d got %h want %h", i, rx_q[i], word_of(exp_adr(i))); end
    end
  endtask

  // Asynchronous reset in the middle of a burst, then a clean restart from BASE.
  task automatic test_reset_mid();
    bit to;
    prep();
    lat_max = 1; rdy_pct = 100; salt = $urandom;
    pulse_start();
    wait_beats(7, to);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wb.wb_cyc !== 1'b0 || wb.wb_stb !== 1'b0) begin errors++; $display("FAIL rst_mid_cyc got %b%b want 00", wb.wb_cyc, wb.wb_stb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    prep();
    pulse_start();
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL rst_mid_done_timeout got none want pulse"); end
    wait_rx(NW, to);
    #1;
    checks++; if (beat_adr_q.size() == 0 || beat_adr_q[0] !== BASE) begin errors++; $display("FAIL rst_mid_first_adr got %h want %h", (beat_adr_q.size() != 0) ? beat_adr_q[0] : 32'hx, BASE); end
    checks++; if (rx_q.size() != NW) begin errors++; $display("FAIL rst_mid_words got %0d want %0d", rx_q.size(), NW); end
    for (int i = 0; i < rx_q.size() && i < NW; i++) begin
      checks++;
      if (rx_q[i] !== word_of(exp_adr(i))) begin errors++; $display("FAIL rst_mid_word%0d got %h want %h", i, rx_q[i], word_of(exp_adr(i))); end
    end
  endtask

  // start while busy is ignored; retry on beat 3 holds the beat unchanged.
  task automatic test_start_busy_rty();
    bit to;
    prep();
    lat_max = 0; rdy_pct = 100; salt = $urandom; rty_beat = 3; rty_left = 3;
    pulse_start();
    wait_beats(2, to);
    pulse_start();
    wait_beats(20, to);
    pulse_start();
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL rty_done_timeout got none want pulse"); end
    wait_rx(NW, to);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rty_adr_q.size() != 3) begin errors++; $display("FAIL rty_cycles got %0d want 3", rty_adr_q.size()); end
    for (int i = 0; i < rty_adr_q.size(); i++) begin
      checks++;
      if (rty_adr_q[i] !== exp_adr(2) || rty_cti_q[i] !== exp_cti(2)) begin
        errors++; $display("FAIL rty_hold%0d got adr %h cti %b want adr %h cti %b", i, rty_adr_q[i], rty_cti_q[i], exp_adr(2), exp_cti(2));
      end
    end
    checks++; if (beat_adr_q.size() != NW) begin errors++; $display("FAIL rty_beat_count got %0d want %0d", beat_adr_q.size(), NW); end
    for (int i = 0; i < beat_adr_q.size() && i < NW; i++) begin
      checks++;
      if (beat_adr_q[i] !== exp_adr(i)) begin errors++; $display("FAIL rty_beat%0d got %h want %h", i, beat_adr_q[i], exp_adr(i)); end
    end
    checks++; if (rx_q.size() != NW) begin errors++; $display("FAIL rty_words got %0d want %0d", rx_q.size(), NW); end
    for (int i = 0; i < rx_q.size() && i < NW; i++) begin
      checks++;
      if (rx_q[i] !== word_of(exp_adr(i))) begin errors++; $display("FAIL rty_word%0d got %h want %h", i, rx_q[i], word_of(exp_adr(i))); end
    end
    checks++; if (done_cnt != 1 || cyc_rise != 3) begin errors++; $display("FAIL rty_restart_ignored got done %0d bursts %0d want 1 3", done_cnt, cyc_rise); end
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_transfer("fast_ack", 0, 100);
    test_transfer("random_ack", 3, 50);
    test_backpressure();
    test_error();
    test_reset_mid();
    test_start_busy_rty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
